// File: rtl/uart_bus_bridge.sv
// ---------------------------------------------------------------------------
// uart_bus_bridge
//
// Turns byte frames from a UART receiver into single 8-bit bus transactions.
// Each bus transaction produces one reply byte for the UART transmitter.
//
//   Write frame : 'W'(0x57) ADDR_HI ADDR_LO DATA -> bus write, reply 'K'(0x4B)
//   Read frame  : 'R'(0x52) ADDR_HI ADDR_LO      -> bus read,  reply = read data
//
// Optional feature macro: UART_BUS_BRIDGE_TIMEOUT_EN
//   When it is defined, a partial frame is abandoned (err pulse, back to IDLE)
//   after TIMEOUT_CYCLES clocks without a new byte. When it is undefined, a
//   partial frame waits indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  maximum idle clocks between bytes of one frame
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous, active-high reset
//   rx_data        received byte
//   rx_data_valid  one-cycle pulse qualifying rx_data
//   rx_data_ready  bridge can take a byte (low while a bus cycle/reply runs)
//   tx_data        reply byte
//   tx_data_valid  reply request, held until tx_data_ready
//   tx_data_ready  transmitter idle
//   bus_addr       bus address
//   bus_data_o     bus write data
//   bus_data_i     combinational bus read data
//   bus_cs         one-cycle bus strobe
//   R_W_n          1 = read, 0 = write (1 whenever no write is strobed)
//   busy           FSM is not in IDLE
//   err            one-cycle pulse on a framing error
// ---------------------------------------------------------------------------
module uart_bus_bridge #(
   parameter int TIMEOUT_CYCLES = 2517500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_data_valid,
   output logic        rx_data_ready,
   output logic [7:0]  tx_data,
   output logic        tx_data_valid,
   input  logic        tx_data_ready,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_data_o,
   input  logic [7:0]  bus_data_i,
   output logic        bus_cs,
   output logic        R_W_n,
   output logic        busy,
   output logic        err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ADDR_HI = 3'd1;
   localparam logic [2:0] S_ADDR_LO = 3'd2;
   localparam logic [2:0] S_DATA    = 3'd3;
   localparam logic [2:0] S_BUS     = 3'd4;
   localparam logic [2:0] S_REPLY   = 3'd5;

   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] ACK_BYTE  = 8'h4B;

   logic [2:0] state;
   logic       is_read;   // latched command of the frame in progress
   logic       accept;
   logic       timeout;

   // Bytes are only taken while a frame is being collected; anything that
   // arrives during the bus cycle or the reply is dropped.
   assign rx_data_ready = (state == S_IDLE) || (state == S_ADDR_HI) ||
                          (state == S_ADDR_LO) || (state == S_DATA);
   assign accept        = rx_data_valid && rx_data_ready;
   assign busy          = (state != S_IDLE);

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] idle_cnt;
   logic             waiting;

   assign waiting = (state == S_ADDR_HI) || (state == S_ADDR_LO) ||
                    (state == S_DATA);

   // Expires on the TIMEOUT_CYCLES-th idle clock; a byte accepted in that
   // same clock wins over the timeout.
   assign timeout = waiting && !accept &&
                    (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (!waiting || accept || timeout) begin
         idle_cnt <= '0;
      end else if (idle_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
         idle_cnt <= idle_cnt + CNT_W'(1);
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         is_read       <= 1'b0;
         bus_addr      <= '0;
         bus_data_o    <= '0;
         bus_cs        <= 1'b0;
         R_W_n         <= 1'b1;
         tx_data       <= '0;
         tx_data_valid <= 1'b0;
         err           <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register in this block
         // updating from the pre-edge values; these defaults make bus_cs and
         // err single-cycle pulses and park R_W_n at read.
         bus_cs <= 1'b0;
         R_W_n  <= 1'b1;
         err    <= 1'b0;

         if (timeout) begin
            state <= S_IDLE;
            err   <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept) begin
                     if ((rx_data == CMD_READ) || (rx_data == CMD_WRITE)) begin
                        is_read <= (rx_data == CMD_READ);
                        state   <= S_ADDR_HI;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               S_ADDR_HI: begin
                  if (accept) begin
                     bus_addr[15:8] <= rx_data;
                     state          <= S_ADDR_LO;
                  end
               end
               S_ADDR_LO: begin
                  if (accept) begin
                     bus_addr[7:0] <= rx_data;
                     if (is_read) begin
                        // Strobe is registered so it coincides with the BUS state.
                        bus_cs <= 1'b1;
                        state  <= S_BUS;
                     end else begin
                        state <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (accept) begin
                     bus_data_o <= rx_data;
                     bus_cs     <= 1'b1;
                     R_W_n      <= 1'b0;
                     state      <= S_BUS;
                  end
               end
               S_BUS: begin
                  // bus_data_i is sampled at the edge that ends the strobe.
                  tx_data       <= is_read ? bus_data_i : ACK_BYTE;
                  tx_data_valid <= 1'b1;
                  state         <= S_REPLY;
               end
               S_REPLY: begin
                  if (tx_data_ready) begin
                     tx_data_valid <= 1'b0;
                     state         <= S_IDLE;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_bus_bridge
//
// Directed bench for uart_bus_bridge with TIMEOUT_CYCLES = 100. A frame-level
// model (byte queue, idle count, pending reply) predicts every output each
// cycle; directed sequences add literal expectations on the observed bus
// transactions, replies and error pulses. Covers the timeout boundary when
// UART_BUS_BRIDGE_TIMEOUT_EN is defined, the indefinite wait otherwise.
// ---------------------------------------------------------------------------
module tb_uart_bus_bridge;

   localparam int T = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_data_valid = 1'b0;
   logic        rx_data_ready;
   logic [7:0]  tx_data;
   logic        tx_data_valid;
   logic        tx_data_ready = 1'b1;
   logic [15:0] bus_addr;
   logic [7:0]  bus_data_o;
   logic [7:0]  bus_data_i = 8'h5A;
   logic        bus_cs;
   logic        R_W_n;
   logic        busy;
   logic        err;

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_data_ready (rx_data_ready),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .bus_addr      (bus_addr),
      .bus_data_o    (bus_data_o),
      .bus_data_i    (bus_data_i),
      .bus_cs        (bus_cs),
      .R_W_n         (R_W_n),
      .busy          (busy),
      .err           (err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   logic [7:0]  frm[$];
   int          idle = 0;
   bit          started = 1'b0;
   bit          reply_pending = 1'b0;
   logic [7:0]  reply_byte = 8'h00;
   bit          m_read = 1'b0;
   logic [15:0] m_addr = 16'h0000;
   logic [7:0]  m_wdata = 8'h00;
   // expectations for the current cycle
   bit e_bus = 1'b0, e_err = 1'b0, e_txv = 1'b0, e_busy = 1'b0, e_rdy = 1'b1;

   // observed DUT events
   int          n_bus = 0, n_err = 0, n_reply = 0;
   logic [15:0] last_addr = 16'h0;
   logic [7:0]  last_wdata = 8'h0, last_reply = 8'h0;
   logic        last_rw = 1'b1;

   always @(negedge clk) begin : cmp
      bit nb;
      bit nerr;
      if (started) begin
         check("bus_cs", 32'(bus_cs), 32'(e_bus));
         check("err", 32'(err), 32'(e_err));
         check("tx_data_valid", 32'(tx_data_valid), 32'(e_txv));
         check("busy", 32'(busy), 32'(e_busy));
         check("rx_data_ready", 32'(rx_data_ready), 32'(e_rdy));
         check("R_W_n", 32'(R_W_n), 32'(e_bus ? m_read : 1'b1));
         if (e_bus) check("bus_addr", 32'(bus_addr), 32'(m_addr));
         if (e_bus && !m_read) check("bus_data_o", 32'(bus_data_o), 32'(m_wdata));
         if (e_txv) check("tx_data", 32'(tx_data), 32'(reply_byte));

         if (bus_cs === 1'b1) begin
            n_bus++;
            last_addr  = bus_addr;
            last_wdata = bus_data_o;
            last_rw    = R_W_n;
         end
         if (err === 1'b1) n_err++;
         if (tx_data_valid === 1'b1 && tx_data_ready && !rst) begin
            n_reply++;
            last_reply = tx_data;
         end
      end

      nb   = 1'b0;
      nerr = 1'b0;
      if (rst) begin
         started       = 1'b1;
         frm.delete();
         idle          = 0;
         reply_pending = 1'b0;
      end else if (e_bus) begin
         reply_pending = 1'b1;
         reply_byte    = m_read ? bus_data_i : 8'h4B;
      end else if (reply_pending) begin
         if (tx_data_ready) reply_pending = 1'b0;
      end else if (rx_data_valid) begin
         frm.push_back(rx_data);
         idle = 0;
         if (frm.size() == 1 && rx_data != 8'h52 && rx_data != 8'h57) begin
            nerr = 1'b1;
            frm.delete();
         end else if ((frm[0] == 8'h52 && frm.size() == 3) ||
                      (frm[0] == 8'h57 && frm.size() == 4)) begin
            nb      = 1'b1;
            m_read  = (frm[0] == 8'h52);
            m_addr  = {frm[1], frm[2]};
            m_wdata = m_read ? 8'h00 : frm[3];
            frm.delete();
         end
      end else if (frm.size() != 0) begin
         idle++;
         if (TO_EN && idle >= T) begin
            nerr = 1'b1;
            frm.delete();
            idle = 0;
         end
      end
      e_bus  = nb;
      e_err  = nerr;
      e_txv  = reply_pending;
      e_rdy  = !(nb || reply_pending);
      e_busy = nb || reply_pending || (frm.size() != 0);
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data       = b;
      rx_data_valid = 1'b1;
      tick();
      rx_data_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy === 1'b1; i++) tick();
      check("wait_idle_busy", 32'(busy), 32'(0));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int b0, e0, r0;

      // Reset values, sampled while rst is still high.
      tick(3);
      check("rst_bus_cs", 32'(bus_cs), 32'(0));
      check("rst_R_W_n", 32'(R_W_n), 32'(1));
      check("rst_bus_addr", 32'(bus_addr), 32'(0));
      check("rst_bus_data_o", 32'(bus_data_o), 32'(0));
      check("rst_tx_data", 32'(tx_data), 32'(0));
      check("rst_tx_data_valid", 32'(tx_data_valid), 32'(0));
      check("rst_err", 32'(err), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_rx_data_ready", 32'(rx_data_ready), 32'(1));
      rst = 1'b0;
      tick(2);

      // Write 57 FE 08 03.
      b0 = n_bus; e0 = n_err; r0 = n_reply;
      send(8'h57); send(8'hFE); send(8'h08); send(8'h03);
      wait_idle(20);
      tick(2);
      check("wr_bus_count", 32'(n_bus - b0), 32'(1));
      check("wr_addr", 32'(last_addr), 32'h0000FE08);
      check("wr_data", 32'(last_wdata), 32'h03);
      check("wr_rw", 32'(last_rw), 32'(0));
      check("wr_reply", 32'(last_reply), 32'h4B);
      check("wr_reply_count", 32'(n_reply - r0), 32'(1));
      check("wr_err_count", 32'(n_err - e0), 32'(0));

      // Read 52 FE 03 with data 01, transmitter busy for 50 cycles.
      b0 = n_bus; r0 = n_reply;
      bus_data_i    = 8'h01;
      tx_data_ready = 1'b0;
      send(8'h52); send(8'hFE); send(8'h03);
      tick(51);
      check("rd_held_valid", 32'(tx_data_valid), 32'(1));
      check("rd_held_data", 32'(tx_data), 32'h01);
      tx_data_ready = 1'b1;
      tick();
      tx_data_ready = 1'b0;
      check("rd_valid_drop", 32'(tx_data_valid), 32'(0));
      check("rd_ready_after", 32'(rx_data_ready), 32'(1));
      check("rd_idle_after", 32'(busy), 32'(0));
      tick(2);
      check("rd_bus_count", 32'(n_bus - b0), 32'(1));
      check("rd_addr", 32'(last_addr), 32'h0000FE03);
      check("rd_rw", 32'(last_rw), 32'(1));
      check("rd_reply", 32'(last_reply), 32'h01);
      check("rd_reply_count", 32'(n_reply - r0), 32'(1));
      bus_data_i = 8'h5A;

      // Bytes offered during BUS and REPLY are dropped.
      b0 = n_bus; e0 = n_err; r0 = n_reply;
      send(8'h57); send(8'h00); send(8'h10); send(8'hAA);
      send(8'h52);
      send(8'h41);
      tick(3);
      tx_data_ready = 1'b1;
      tick();
      tx_data_ready = 1'b0;
      wait_idle(10);
      tick(2);
      check("drop_bus_count", 32'(n_bus - b0), 32'(1));
      check("drop_err_count", 32'(n_err - e0), 32'(0));
      check("drop_reply_count", 32'(n_reply - r0), 32'(1));
      check("drop_addr", 32'(last_addr), 32'h00000010);
      check("drop_data", 32'(last_wdata), 32'hAA);
      tx_data_ready = 1'b1;

      // Unknown command byte.
      b0 = n_bus; e0 = n_err;
      send(8'h41);
      tick(2);
      check("bad_cmd_err_count", 32'(n_err - e0), 32'(1));
      check("bad_cmd_bus_count", 32'(n_bus - b0), 32'(0));
      check("bad_cmd_busy", 32'(busy), 32'(0));

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
      // 100 idle cycles after a byte: frame abandoned.
      b0 = n_bus; e0 = n_err;
      send(8'h57); send(8'hFE);
      tick(100);
      check("to_busy", 32'(busy), 32'(0));
      tick(2);
      check("to_err_count", 32'(n_err - e0), 32'(1));
      check("to_bus_count", 32'(n_bus - b0), 32'(0));

      // Byte arriving on the 100th cycle is still accepted.
      b0 = n_bus; e0 = n_err;
      send(8'h57); send(8'hFE);
      tick(99);
      send(8'h08); send(8'h03);
      wait_idle(20);
      tick(2);
      check("edge_err_count", 32'(n_err - e0), 32'(0));
      check("edge_bus_count", 32'(n_bus - b0), 32'(1));
      check("edge_addr", 32'(last_addr), 32'h0000FE08);
`else
      // No timeout: a partial frame waits indefinitely.
      b0 = n_bus; e0 = n_err;
      send(8'h57); send(8'hFE);
      tick(10000);
      check("wait_busy", 32'(busy), 32'(1));
      send(8'h08); send(8'h03);
      wait_idle(20);
      tick(2);
      check("wait_err_count", 32'(n_err - e0), 32'(0));
      check("wait_bus_count", 32'(n_bus - b0), 32'(1));
      check("wait_addr", 32'(last_addr), 32'h0000FE08);
      check("wait_data", 32'(last_wdata), 32'h03);
`endif

      // Reset together with the DATA byte: no bus cycle, no reply.
      b0 = n_bus; r0 = n_reply;
      send(8'h57); send(8'hFE); send(8'h08);
      rx_data       = 8'h03;
      rx_data_valid = 1'b1;
      rst           = 1'b1;
      tick();
      rx_data_valid = 1'b0;
      rst           = 1'b0;
      check("rstf_bus_cs", 32'(bus_cs), 32'(0));
      check("rstf_R_W_n", 32'(R_W_n), 32'(1));
      check("rstf_bus_addr", 32'(bus_addr), 32'(0));
      check("rstf_bus_data_o", 32'(bus_data_o), 32'(0));
      check("rstf_tx_data", 32'(tx_data), 32'(0));
      check("rstf_tx_data_valid", 32'(tx_data_valid), 32'(0));
      check("rstf_busy", 32'(busy), 32'(0));
      tick(5);
      check("rstf_bus_count", 32'(n_bus - b0), 32'(0));
      check("rstf_reply_count", 32'(n_reply - r0), 32'(0));

      // Reset during REPLY: bus cycle stands, reply abandoned.
      b0 = n_bus; r0 = n_reply;
      tx_data_ready = 1'b0;
      send(8'h52); send(8'h12); send(8'h34);
      tick(5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tx_data_ready = 1'b1;
      tick(5);
      check("rstr_valid", 32'(tx_data_valid), 32'(0));
      check("rstr_bus_count", 32'(n_bus - b0), 32'(1));
      check("rstr_reply_count", 32'(n_reply - r0), 32'(0));

      tick(3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
